// File: rtl/m_axi_pkg.sv
// Shared AXI encodings, FSM state codes and helpers
// for the AXI read splitter.
package m_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int AXI_4KB = 4096;

    localparam logic [3:0] AXI_CACHE_MOD = 4'b0010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/m_axi_rd_split_if.sv
// AXI4 read address and read data channels
// bundled for the splitter and its slave.
interface m_axi_rd_split_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [USER_W-1:0] aruser;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize,
        output arburst, arlock, arcache,
        output arprot, arqos, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize,
        input  arburst, arlock, arcache,
        input  arprot, arqos, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_len_fifo.sv
// Small synchronous FIFO holding the beat count
// of each issued burst until its rlast arrives.
module axi_len_fifo
    import m_axi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/m_axi_rd_split.sv
// AXI4 read master: splits one user read into INCR
// bursts and streams the returned beats straight out.
module m_axi_rd_split
    import m_axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXI_ARUSER_WIDTH = 1,
    parameter int MAX_BURST_LEN        = 16,
    parameter int MAX_OUTSTANDING      = 4,
    parameter int LEN_WIDTH            = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]          rd_len,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_vld,
    input  logic                          rd_ready,
    output logic                          rd_busy,
    output logic                          rd_done,
    output logic                          rd_err,
    m_axi_rd_split_if.master              m_axi
);

    localparam int AW   = C_M_AXI_ADDR_WIDTH;
    localparam int SIZE = clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam int OW   = clog2(MAX_OUTSTANDING + 1);

    localparam logic [AW-1:0] ALIGN = AW'((1 << SIZE) - 1);

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        araddr_q, araddr_d;
    logic [7:0]           arlen_q, arlen_d;
    logic [8:0]           arbeats_q, arbeats_d;
    logic                 arvalid_q, arvalid_d;
    logic [LEN_WIDTH-1:0] total_q, total_d;
    logic [LEN_WIDTH-1:0] issue_q, issue_d;
    logic [LEN_WIDTH-1:0] rcv_q, rcv_d;
    logic [8:0]           bcnt_q, bcnt_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 err_q, err_d;

    logic       run;
    logic       rready_w;
    logic       ar_hs;
    logic       r_hs;
    logic       last_hs;
    logic       can_issue;
    logic [8:0] rem_sat;
    logic [12:0] to4k;
    logic [8:0] beats;
    logic [8:0] bcnt_inc;
    logic       len_err;
    logic       resp_err;
    logic [8:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign run      = (state_q == ST_RUN);
    assign rready_w = rd_ready & run;
    assign ar_hs    = arvalid_q & m_axi.arready;
    assign r_hs     = m_axi.rvalid & rready_w;
    assign last_hs  = r_hs & m_axi.rlast;

    // Burst size is capped by the remaining count, the burst
    // limit and the distance to the next 4 KB page.
    always_comb begin
        if (32'(issue_q) > 32'(MAX_BURST_LEN)) begin
            rem_sat = 9'(MAX_BURST_LEN);
        end else begin
            rem_sat = 9'(issue_q);
        end
        to4k = (13'(AXI_4KB) - {1'b0, addr_q[11:0]}) >> SIZE;
        if (32'(to4k) < 32'(rem_sat)) begin
            beats = 9'(to4k);
        end else begin
            beats = rem_sat;
        end
    end

    assign can_issue = run & ~arvalid_q & ~fifo_full
                     & (issue_q != '0)
                     & (32'(outst_q) < 32'(MAX_OUTSTANDING));

    assign bcnt_inc = bcnt_q + 9'd1;

    always_comb begin
        len_err = 1'b0;
        if (last_hs) begin
            len_err = fifo_empty | (bcnt_inc != fifo_head);
        end else if (r_hs && !fifo_empty) begin
            len_err = (bcnt_inc >= fifo_head);
        end
    end

    assign resp_err = r_hs & ((m_axi.rresp != AXI_RESP_OKAY)
                            | (m_axi.rid != '0));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arbeats_d = arbeats_q;
        arvalid_d = arvalid_q;
        total_d   = total_q;
        issue_d   = issue_q;
        rcv_d     = rcv_q;
        bcnt_d    = bcnt_q;
        outst_d   = outst_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    err_d   = 1'b0;
                    total_d = rd_len;
                    issue_d = rd_len;
                    rcv_d   = '0;
                    bcnt_d  = '0;
                    addr_d  = rd_addr & ~ALIGN;
                    state_d = (rd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_hs && (rcv_q + LEN_WIDTH'(1) == total_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (can_issue) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_q;
            arlen_d   = 8'(beats - 9'd1);
            arbeats_d = beats;
        end

        if (ar_hs) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + (AW'(arbeats_q) << SIZE);
            issue_d   = issue_q - LEN_WIDTH'(arbeats_q);
        end

        if (r_hs) begin
            rcv_d  = rcv_q + LEN_WIDTH'(1);
            bcnt_d = m_axi.rlast ? 9'd0 : bcnt_inc;
            err_d  = err_q | len_err | resp_err;
        end

        unique case ({ar_hs, last_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arbeats_q <= '0;
            arvalid_q <= 1'b0;
            total_q   <= '0;
            issue_q   <= '0;
            rcv_q     <= '0;
            bcnt_q    <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arbeats_q <= arbeats_d;
            arvalid_q <= arvalid_d;
            total_q   <= total_d;
            issue_q   <= issue_d;
            rcv_q     <= rcv_d;
            bcnt_q    <= bcnt_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    axi_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (9)
    ) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ar_hs),
        .din_i   (arbeats_q),
        .pop_i   (last_hs),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_axi.arid    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(SIZE);
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE_MOD;
    assign m_axi.arprot  = 3'd0;
    assign m_axi.arqos   = 4'd0;
    assign m_axi.aruser  = {C_M_AXI_ARUSER_WIDTH{1'b0}};
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_w;

    assign rd_data = m_axi.rdata;
    assign rd_vld  = m_axi.rvalid & run;
    assign rd_busy = (state_q != ST_IDLE);
    assign rd_done = (state_q == ST_DONE);
    assign rd_err  = err_q;

endmodule

// File: tb/tb_m_axi_rd_split.sv
// Bench for m_axi_rd_split: random AXI slave, burst
// reference model and scoreboard on AR and user data.
module tb_m_axi_rd_split;
    import m_axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] rd_len;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          rd_ready;
    logic          rd_busy;
    logic          rd_done;
    logic          rd_err;

    always #5 clk = ~clk;

    m_axi_rd_split_if #(
        .ID_W(1), .ADDR_W(AW), .DATA_W(DW), .USER_W(1)
    ) bus ();

    m_axi_rd_split #(
        .C_M_AXI_ID_WIDTH     (1),
        .C_M_AXI_ADDR_WIDTH   (AW),
        .C_M_AXI_DATA_WIDTH   (DW),
        .C_M_AXI_ARUSER_WIDTH (1),
        .MAX_BURST_LEN        (16),
        .MAX_OUTSTANDING      (4),
        .LEN_WIDTH            (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_start (rd_start),
        .rd_addr  (rd_addr),
        .rd_len   (rd_len),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .rd_ready (rd_ready),
        .rd_busy  (rd_busy),
        .rd_done  (rd_done),
        .rd_err   (rd_err),
        .m_axi    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [31:0] exp_dat[$];
    logic        exp_err;

    int  ar_n, rl_n, rbeats, done_n;
    bit  chk_rr;
    int  rmode;
    bit  r_hold;
    int  err_at;
    int  gbeat;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected", nm);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC3A5_0F0F;
    endfunction

    // Reference: walk the transfer page by page.
    task automatic model(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int rem, b, to4k;
        a   = addr & ~32'h3;
        rem = len;
        while (rem > 0) begin
            b    = (rem > 16) ? 16 : rem;
            to4k = (4096 - int'(a % 4096)) / 4;
            if (b > to4k) b = to4k;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(8'(b - 1));
            for (int i = 0; i < b; i++) exp_dat.push_back(pat(a + 32'(4 * i)));
            a   = a + 32'(4 * b);
            rem = rem - b;
        end
    endtask

    // AXI slave
    logic [31:0] sq_addr[$];
    int          sq_len[$];
    int          beat_i;
    bit          r_hs;
    bit          rst_seen;

    initial begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = AXI_RESP_OKAY;
        bus.rid     = '0;
        beat_i      = 0;
        gbeat       = 0;
        rst_seen    = 0;
        forever begin
            @(negedge clk);
            r_hs = 0;
            if (rst) begin
                sq_addr.delete();
                sq_len.delete();
                beat_i   = 0;
                rst_seen = 1;
            end else begin
                if (bus.arvalid && bus.arready) begin
                    sq_addr.push_back(bus.araddr);
                    sq_len.push_back(int'(bus.arlen));
                end
                if (bus.rvalid && bus.rready) begin
                    r_hs = 1;
                    gbeat++;
                    if (beat_i == sq_len[0]) begin
                        void'(sq_addr.pop_front());
                        void'(sq_len.pop_front());
                        beat_i = 0;
                    end else begin
                        beat_i++;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.arready = ($urandom_range(0, 3) != 0);
            if (rst_seen) begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                rst_seen   = 0;
            end else if (!(bus.rvalid && !r_hs)) begin
                if (!r_hold && sq_addr.size() > 0
                    && $urandom_range(0, 3) != 0) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = pat(sq_addr[0] + 32'(4 * beat_i));
                    bus.rlast  = (beat_i == sq_len[0]);
                    bus.rresp  = (gbeat == err_at)
                               ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rlast  = 1'b0;
                end
            end
        end
    end

    // User-side ready pattern
    initial begin
        int cyc;
        cyc      = 0;
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rmode)
                1:       rd_ready = (cyc % 3 == 0);
                2:       rd_ready = ($urandom_range(0, 1) == 1);
                default: rd_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    bit          prev_pend;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 0;
            ar_n      = 0;
            rl_n      = 0;
        end else begin
            if (prev_pend) begin
                chk("ar_stable",
                    {bus.arvalid, bus.araddr, bus.arlen},
                    {1'b1, prev_addr, prev_len});
            end
            prev_pend = bus.arvalid && !bus.arready;
            prev_addr = bus.araddr;
            prev_len  = bus.arlen;
            if (bus.arvalid && bus.arready) begin
                chk("ar_const",
                    {bus.arid, bus.arsize, bus.arburst,
                     bus.arlock, bus.arcache, bus.arprot,
                     bus.arqos, bus.aruser},
                    {1'b0, 3'd2, AXI_BURST_INCR, 1'b0,
                     4'b0010, 3'd0, 4'd0, 1'b0});
                chk("ar_outstanding", (ar_n - rl_n) < 4, 1);
                if (exp_ar_addr.size() == 0) begin
                    fail_now("ar_unexpected");
                end else begin
                    chk("araddr", bus.araddr, exp_ar_addr.pop_front());
                    chk("arlen", bus.arlen, exp_ar_len.pop_front());
                end
                ar_n++;
            end
            if (bus.rvalid && bus.rready && bus.rlast) rl_n++;
            if (rd_vld && rd_ready) begin
                rbeats++;
                if (exp_dat.size() == 0) begin
                    fail_now("rd_data_extra");
                end else begin
                    chk("rd_data", rd_data, exp_dat.pop_front());
                end
            end
            if (rd_done) begin
                done_n++;
                chk("rd_err_at_done", rd_err, exp_err);
                chk("ar_left_at_done", exp_ar_addr.size(), 0);
                chk("beats_left_at_done", exp_dat.size(), 0);
            end
            if (chk_rr && rd_busy) begin
                chk("rready_track", bus.rready, rd_ready && !rd_done);
            end
        end
    end

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_n == d0; i++) begin
            @(posedge clk);
        end
        chk("done_seen", done_n != d0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_n - d0, 1);
    endtask

    task automatic kick(input logic [31:0] a, input int len);
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        rd_addr  = a;
        rd_len   = LW'(len);
        @(posedge clk);
        #1;
        rd_start = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input int len,
                       input int errb, input bit poke,
                       input bit chk_clr);
        int d0;
        model(a, len);
        exp_err = (errb >= 0);
        err_at  = (errb >= 0) ? gbeat + errb : -1;
        d0      = done_n;
        kick(a, len);
        if (chk_clr) chk("err_clear_on_start", rd_err, 0);
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            rd_start = 1'b1;
            rd_addr  = 32'h2000;
            rd_len   = 3;
            @(posedge clk);
            #1;
            rd_start = 1'b0;
        end
        wait_done(d0, 4000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, d0;
        rst      = 1'b1;
        rd_start = 1'b0;
        rd_addr  = '0;
        rd_len   = '0;
        rmode    = 0;
        r_hold   = 0;
        chk_rr   = 0;
        err_at   = -1;
        exp_err  = 0;
        rbeats   = 0;
        done_n   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_done", rd_done, 0);
        chk("rst_err", rd_err, 0);
        rst = 1'b0;

        run(32'h1000, 40, -1, 1, 0);
        run(32'h0FF0, 8, -1, 0, 0);

        a0 = ar_n;
        run(32'h0, 0, -1, 0, 0);
        chk("zero_len_no_ar", ar_n - a0, 0);

        // Data held back: only four bursts may be in flight.
        model(32'h0, 128);
        exp_err = 0;
        err_at  = -1;
        r_hold  = 1;
        a0      = ar_n;
        d0      = done_n;
        kick(32'h0, 128);
        repeat (50) @(posedge clk);
        #1;
        chk("ar_during_hold", ar_n - a0, 4);
        r_hold = 0;
        wait_done(d0, 4000);

        run(32'h0000_2000, 20, 4, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", rd_err, 1);

        rmode  = 1;
        chk_rr = 1;
        run(32'h0000_5F80, 32, -1, 0, 1);
        chk_rr = 0;
        rmode  = 0;

        // Reset in the middle of a transfer.
        model(32'h3000, 64);
        exp_err = 1;
        err_at  = gbeat + 3;
        d0      = done_n;
        r0      = rbeats;
        kick(32'h3000, 64);
        for (int i = 0; i < 2000 && rbeats - r0 < 10; i++) begin
            @(posedge clk);
        end
        chk("reach_beat10", rbeats - r0 >= 10, 1);
        chk("err_before_rst", rd_err, 1);
        #1;
        rst = 1'b1;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_dat.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_arvalid", bus.arvalid, 0);
        chk("midrst_busy", rd_busy, 0);
        chk("midrst_err", rd_err, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_ar", ar_n, 0);
        chk("midrst_no_done", done_n - d0, 0);
        run(32'h4000, 4, -1, 0, 0);

        rmode = 2;
        for (int t = 0; t < 10; t++) begin
            logic [31:0] a;
            int len, eb;
            a   = $urandom & 32'h0000_FFFF;
            if (t % 3 == 0) a = (a & 32'hFFFF_F000) | 32'hFC0;
            len = $urandom_range(1, 80);
            eb  = ($urandom_range(0, 2) == 0)
                ? $urandom_range(0, len - 1) : -1;
            run(a, len, eb, 0, 0);
        end
        rmode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
